// File: rtl/pipeline_reg_mw_hs.sv
// MEM-to-WB pipeline register with a valid/ready handshake. SKID_EN selects a
// two-entry skid buffer (ready fully registered) or a single stall register.
module pipeline_reg_mw_hs #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SKID_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_m_i,
    output logic             ready_m_o,
    input  logic             reg_wr_en_m_i,
    input  logic [1:0]       result_src_m_i,
    input  logic [WIDTH-1:0] alu_result_m_i,
    input  logic [WIDTH-1:0] read_data_m_i,
    input  logic [4:0]       wr_addr_m_i,
    input  logic [WIDTH-1:0] pc_plus_4_m_i,
    output logic             valid_w_o,
    input  logic             ready_w_i,
    output logic             reg_wr_en_w_o,
    output logic [4:0]       wr_addr_w_o,
    output logic [WIDTH-1:0] result_w_o
);

    logic             accept;
    logic             transfer;
    logic             ready_s;
    logic             valid_s;
    logic             in_wen;
    logic [WIDTH-1:0] in_res;

    logic             main_wen_q;
    logic [4:0]       main_addr_q;
    logic [WIDTH-1:0] main_res_q;

    // Source 11 is reserved and falls back to the ALU result.
    function automatic logic [WIDTH-1:0] sel_result(
        input logic [1:0]       src,
        input logic [WIDTH-1:0] alu,
        input logic [WIDTH-1:0] rdata,
        input logic [WIDTH-1:0] link
    );
        logic [WIDTH-1:0] res;
        case (src)
            2'b01:   res = rdata;
            2'b10:   res = link;
            default: res = alu;
        endcase
        return res;
    endfunction

    assign in_wen   = reg_wr_en_m_i && (wr_addr_m_i != 5'd0);
    assign in_res   = sel_result(result_src_m_i, alu_result_m_i, read_data_m_i, pc_plus_4_m_i);
    assign accept   = valid_m_i && ready_s && !flush_i;
    assign transfer = valid_s && ready_w_i;

    generate
        if (SKID_EN != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_FULL  = 2'd1,
                ST_SKID  = 2'd2
            } state_e;

            state_e           state_q;
            state_e           state_d;
            logic             load_new;
            logic             load_from_skid;
            logic             load_skid;
            logic             skid_wen_q;
            logic [4:0]       skid_addr_q;
            logic [WIDTH-1:0] skid_res_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= ST_EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            always_comb begin
                state_d = state_q;
                if (flush_i) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: if (accept) state_d = ST_FULL;
                        ST_FULL: begin
                            if (accept && !transfer) begin
                                state_d = ST_SKID;
                            end else if (!accept && transfer) begin
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_SKID:  if (transfer) state_d = ST_FULL;
                        default:  state_d = ST_EMPTY;
                    endcase
                end
            end

            // Ready decodes registered state only, never ready_w_i.
            always_comb begin
                ready_s = (state_q != ST_SKID) && !rst_i;
                valid_s = (state_q != ST_EMPTY);
            end

            always_comb begin
                load_new       = accept && ((state_q == ST_EMPTY) || transfer);
                load_skid      = accept && (state_q == ST_FULL) && !transfer;
                load_from_skid = (state_q == ST_SKID) && transfer && !flush_i;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    main_wen_q  <= 1'b0;
                    main_addr_q <= 5'd0;
                    main_res_q  <= '0;
                    skid_wen_q  <= 1'b0;
                end else begin
                    if (flush_i) begin
                        main_wen_q <= 1'b0;
                        skid_wen_q <= 1'b0;
                    end else if (load_new) begin
                        main_wen_q  <= in_wen;
                        main_addr_q <= wr_addr_m_i;
                        main_res_q  <= in_res;
                    end else if (load_from_skid) begin
                        main_wen_q  <= skid_wen_q;
                        main_addr_q <= skid_addr_q;
                        main_res_q  <= skid_res_q;
                    end
                    if (load_skid) begin
                        skid_wen_q <= in_wen;
                    end
                end
            end

            // Skid payload needs no reset; the state says whether it is live.
            always_ff @(posedge clk_i) begin
                if (load_skid) begin
                    skid_addr_q <= wr_addr_m_i;
                    skid_res_q  <= in_res;
                end
            end
        end else begin : g_stall
            logic vld_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q <= 1'b0;
                end else if (flush_i) begin
                    vld_q <= 1'b0;
                end else if (accept) begin
                    vld_q <= 1'b1;
                end else if (transfer) begin
                    vld_q <= 1'b0;
                end
            end

            assign ready_s = (ready_w_i || !vld_q) && !rst_i;
            assign valid_s = vld_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    main_wen_q  <= 1'b0;
                    main_addr_q <= 5'd0;
                    main_res_q  <= '0;
                end else if (flush_i) begin
                    main_wen_q <= 1'b0;
                end else if (accept) begin
                    main_wen_q  <= in_wen;
                    main_addr_q <= wr_addr_m_i;
                    main_res_q  <= in_res;
                end
            end
        end
    endgenerate

    assign ready_m_o     = ready_s;
    assign valid_w_o     = valid_s;
    assign reg_wr_en_w_o = main_wen_q && valid_s;
    assign wr_addr_w_o   = main_addr_q;
    assign result_w_o    = main_res_q;

endmodule

// File: tb/tb_pipeline_reg_mw_hs.sv
// Bench for pipeline_reg_mw_hs: both modes side by side on shared stimulus,
// each checked against a queue-based model of the handshake.
module tb_pipeline_reg_mw_hs;
    localparam int W = 32;

    typedef struct packed {
        logic         wen;
        logic [4:0]   addr;
        logic [W-1:0] res;
    } ent_t;

    logic         clk;
    logic         rst, flush, vm, wen_m, rdy;
    logic [1:0]   src;
    logic [W-1:0] alu, rd, pc;
    logic [4:0]   addr;

    logic         o1_ready, o1_valid, o1_wen;
    logic [4:0]   o1_addr;
    logic [W-1:0] o1_res;
    logic         o0_ready, o0_valid, o0_wen;
    logic [4:0]   o0_addr;
    logic [W-1:0] o0_res;

    int   checks = 0;
    int   errors = 0;
    ent_t q1[$];
    ent_t q0[$];
    bit   clean1, clean0;

    pipeline_reg_mw_hs #(.WIDTH(W), .SKID_EN(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_m_i(vm), .ready_m_o(o1_ready),
        .reg_wr_en_m_i(wen_m), .result_src_m_i(src), .alu_result_m_i(alu),
        .read_data_m_i(rd), .wr_addr_m_i(addr), .pc_plus_4_m_i(pc),
        .valid_w_o(o1_valid), .ready_w_i(rdy), .reg_wr_en_w_o(o1_wen),
        .wr_addr_w_o(o1_addr), .result_w_o(o1_res)
    );

    pipeline_reg_mw_hs #(.WIDTH(W), .SKID_EN(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_m_i(vm), .ready_m_o(o0_ready),
        .reg_wr_en_m_i(wen_m), .result_src_m_i(src), .alu_result_m_i(alu),
        .read_data_m_i(rd), .wr_addr_m_i(addr), .pc_plus_4_m_i(pc),
        .valid_w_o(o0_valid), .ready_w_i(rdy), .reg_wr_en_w_o(o0_wen),
        .wr_addr_w_o(o0_addr), .result_w_o(o0_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk_entry();
        ent_t e;
        e.wen  = wen_m && (addr != 5'd0);
        e.addr = addr;
        e.res  = (src == 2'b01) ? rd : (src == 2'b10) ? pc : alu;
        return e;
    endfunction

    // Capacity is two entries with a skid buffer, otherwise one entry that
    // can be replaced in the same cycle it drains.
    function automatic bit exp_ready(input int mode, input int sz);
        if (rst) return 1'b0;
        if (mode == 1) return sz < 2;
        return rdy || (sz == 0);
    endfunction

    task automatic check_mode(input int mode, input logic ready, input logic valid,
                              input logic wen, input logic [4:0] oaddr, input logic [W-1:0] res);
        ent_t h;
        int   sz;
        bit   cl;
        h  = '0;
        sz = (mode == 1) ? q1.size() : q0.size();
        cl = (mode == 1) ? clean1 : clean0;
        if (sz > 0) h = (mode == 1) ? q1[0] : q0[0];
        chk($sformatf("m%0d_ready", mode), W'(ready), W'(exp_ready(mode, sz)));
        chk($sformatf("m%0d_valid", mode), W'(valid), W'(sz > 0));
        chk($sformatf("m%0d_wen", mode), W'(wen), W'((sz > 0) && h.wen));
        if (sz > 0) begin
            chk($sformatf("m%0d_result", mode), res, h.res);
            chk($sformatf("m%0d_addr", mode), W'(oaddr), W'(h.addr));
        end else if (cl) begin
            chk($sformatf("m%0d_rst_result", mode), res, '0);
            chk($sformatf("m%0d_rst_addr", mode), W'(oaddr), '0);
        end
    endtask

    task automatic update_model(input int mode);
        int sz;
        bit acc, xfer;
        sz = (mode == 1) ? q1.size() : q0.size();
        if (rst) begin
            if (mode == 1) begin q1.delete(); clean1 = 1'b1; end
            else begin q0.delete(); clean0 = 1'b1; end
        end else if (flush) begin
            if (mode == 1) q1.delete();
            else q0.delete();
        end else begin
            acc  = vm && exp_ready(mode, sz);
            xfer = (sz > 0) && rdy;
            if (mode == 1) begin
                if (xfer) void'(q1.pop_front());
                if (acc) begin q1.push_back(mk_entry()); clean1 = 1'b0; end
            end else begin
                if (xfer) void'(q0.pop_front());
                if (acc) begin q0.push_back(mk_entry()); clean0 = 1'b0; end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_mode(1, o1_ready, o1_valid, o1_wen, o1_addr, o1_res);
        check_mode(0, o0_ready, o0_valid, o0_wen, o0_addr, o0_res);
        update_model(1);
        update_model(0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; flush = 0; vm = 0; wen_m = 0; rdy = 0;
        src = 2'b00; alu = '0; rd = '0; pc = '0; addr = 5'd0;
        @(posedge clk);
        #1;
        clean1 = 1'b1;
        clean0 = 1'b1;

        // Reset held, then released
        rdy = 1;
        cycle();
        chk("rst_ready1", W'(o1_ready), 0);
        chk("rst_ready0", W'(o0_ready), 0);
        rst = 0;
        cycle();
        chk("post_rst_ready1", W'(o1_ready), 1);

        // Stream of three loads
        vm = 1; wen_m = 1; src = 2'b01; addr = 5'd5;
        rd = 32'hA; cycle();
        chk("stream_a", o1_res, 32'hA);
        chk("stream_wen", W'(o1_wen), 1);
        rd = 32'hB; cycle();
        chk("stream_b", o1_res, 32'hB);
        rd = 32'hC; cycle();
        chk("stream_c", o0_res, 32'hC);
        vm = 0; cycle();
        chk("stream_drained", W'(o1_valid), 0);

        // Backpressure into the skid entry
        vm = 1; src = 2'b00; alu = 32'h10; cycle();
        rdy = 0; alu = 32'h20; cycle();
        chk("bp_ready1", W'(o1_ready), 0);
        chk("bp_ready0", W'(o0_ready), 0);
        vm = 0; rdy = 1; cycle();
        chk("bp_second", o1_res, 32'h20);
        chk("bp_ready_back", W'(o1_ready), 1);
        cycle();

        // x0 write suppression and link value
        vm = 1; wen_m = 1; addr = 5'd0; src = 2'b00; alu = 32'h77; cycle();
        chk("x0_wen", W'(o1_wen), 0);
        addr = 5'd1; src = 2'b10; pc = 32'h104; cycle();
        chk("link_res", o1_res, 32'h104);
        vm = 0; cycle();

        // Flush from SKID with a live input
        rdy = 0; vm = 1; src = 2'b00; addr = 5'd3; alu = 32'h40; cycle();
        alu = 32'h50; cycle();
        chk("fl_skid_ready", W'(o1_ready), 0);
        flush = 1; alu = 32'h60; cycle();
        chk("fl_valid1", W'(o1_valid), 0);
        chk("fl_valid0", W'(o0_valid), 0);
        flush = 0; vm = 0; rdy = 1; cycle(); cycle();

        // Reset together with flush mid-stream
        vm = 1; rdy = 0; alu = 32'h70; cycle();
        alu = 32'h71; cycle();
        rst = 1; flush = 1; cycle();
        chk("mid_rst_res", o1_res, 0);
        chk("mid_rst_addr", W'(o1_addr), 0);
        chk("mid_rst_valid", W'(o1_valid), 0);
        chk("mid_rst_ready", W'(o1_ready), 0);
        cycle();
        rst = 0; flush = 0; vm = 0; cycle();
        chk("mid_rst_release", W'(o1_ready), 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            vm    = ($urandom_range(0, 9) < 7);
            wen_m = ($urandom_range(0, 1) == 1);
            src   = 2'($urandom_range(0, 3));
            alu   = $urandom;
            rd    = $urandom;
            pc    = $urandom;
            addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdy   = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 149) == 0);
            cycle();
        end
        vm = 0; flush = 0; rst = 0; rdy = 1;
        for (int i = 0; i < 4; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
